// File: rtl/imager_pkg.sv
// Shared definitions for the imager frame scheduler: state encoding and
// the fixed widths used across the scheduler and its selector.
package imager_pkg;

    localparam int MAX_CAMS    = 8;
    localparam int FRAME_CNT_W = 16;
    localparam int CAM_IDX_W   = 3;
    // Pointer must be able to sit one past the last camera (0..MAX_CAMS).
    localparam int PTR_W       = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SELECT    = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GAP       = 3'd4
    } sched_state_e;

endpackage

// File: rtl/imager_rr_select.sv
// Combinational round-robin finder: lowest enabled camera index that is
// greater than or equal to the pointer.
module imager_rr_select
    import imager_pkg::*;
#(
    parameter int NUM_CAMS = 2
) (
    input  logic [NUM_CAMS-1:0]  mask,
    input  logic [PTR_W-1:0]     ptr,
    output logic [CAM_IDX_W-1:0] idx,
    output logic                 found
);

    logic [NUM_CAMS-1:0] eligible;

    generate
        for (genvar gi = 0; gi < NUM_CAMS; gi++) begin : g_elig
            assign eligible[gi] = mask[gi] && (PTR_W'(gi) >= ptr);
        end
    endgenerate

    // Descending scan so the lowest eligible index is the one left standing.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = NUM_CAMS - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                idx   = CAM_IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/imager_frame_scheduler.sv
// Multi-camera frame scheduler: sweeps enabled cameras round-robin, issues
// capture starts, watches for done/timeout and paces repeated sweeps.
module imager_frame_scheduler
    import imager_pkg::*;
#(
    parameter int NUM_CAMS = 2,
    parameter int PERIOD_W = 24
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_CAMS-1:0]    cfg_enable_mask,
    input  logic                   cfg_continuous,
    input  logic [PERIOD_W-1:0]    cfg_period,
    input  logic [PERIOD_W-1:0]    cfg_timeout,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   clear_errors,
    input  logic [NUM_CAMS-1:0]    controller_busy,
    input  logic [NUM_CAMS-1:0]    frame_capture_done,
    input  logic [NUM_CAMS-1:0]    fifo_afull,
    output logic [NUM_CAMS-1:0]    frame_capture_start,
    output logic [NUM_CAMS-1:0]    cam_reset,
    output logic [CAM_IDX_W-1:0]   active_cam,
    output logic                   busy,
    output logic                   sweep_done,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic                   err_timeout,
    output logic                   err_overrun,
    output logic                   err_config
);

    sched_state_e state_q, state_d;

    logic [NUM_CAMS-1:0]    mask_q, mask_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [CAM_IDX_W-1:0]   cam_q, cam_d;
    logic                   pend_stop_q, pend_stop_d;
    logic                   gap_entry_q, gap_entry_d;
    logic [PERIOD_W-1:0]    period_cnt_q, period_cnt_d;
    logic [PERIOD_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;
    logic [NUM_CAMS-1:0]    start_q, start_d;
    logic [NUM_CAMS-1:0]    cam_reset_q, cam_reset_d;
    logic                   busy_q, busy_d;
    logic                   sweep_done_q, sweep_done_d;
    logic                   err_timeout_q, err_timeout_d;
    logic                   err_overrun_q, err_overrun_d;
    logic                   err_config_q, err_config_d;

    logic [CAM_IDX_W-1:0]   sel_idx;
    logic                   sel_found;
    logic [NUM_CAMS-1:0]    sel_onehot;
    logic [NUM_CAMS-1:0]    act_onehot;
    logic [NUM_CAMS-1:0]    above_active;
    logic                   sel_blocked;
    logic                   act_done;
    logic                   timed_out;
    logic [PERIOD_W-1:0]    period_inc;
    logic [PERIOD_W-1:0]    wait_inc;
    logic                   sweep_begin;
    logic                   set_timeout;
    logic                   set_overrun;
    logic                   set_config;

    imager_rr_select #(
        .NUM_CAMS (NUM_CAMS)
    ) u_rr_select (
        .mask  (mask_q),
        .ptr   (ptr_q),
        .idx   (sel_idx),
        .found (sel_found)
    );

    generate
        for (genvar gi = 0; gi < NUM_CAMS; gi++) begin : g_cam
            assign sel_onehot[gi]   = (sel_idx == CAM_IDX_W'(gi));
            assign act_onehot[gi]   = (cam_q == CAM_IDX_W'(gi));
            assign above_active[gi] = mask_q[gi] && (CAM_IDX_W'(gi) > cam_q);
        end
    endgenerate

    assign sel_blocked = |((fifo_afull | controller_busy) & sel_onehot);
    assign act_done    = |(frame_capture_done & act_onehot);

    // Both counters report elapsed cycles including the current one, so a
    // limit of N fires exactly N cycles after the clearing edge.
    assign period_inc = (&period_cnt_q) ? period_cnt_q : period_cnt_q + PERIOD_W'(1);
    assign wait_inc   = (&wait_cnt_q)   ? wait_cnt_q   : wait_cnt_q + PERIOD_W'(1);
    assign timed_out  = (cfg_timeout != '0) && (wait_inc >= cfg_timeout);

    always_comb begin
        state_d       = state_q;
        mask_d        = mask_q;
        ptr_d         = ptr_q;
        cam_d         = cam_q;
        pend_stop_d   = pend_stop_q | (stop && (state_q != ST_IDLE));
        gap_entry_d   = 1'b0;
        period_cnt_d  = period_inc;
        wait_cnt_d    = (state_q == ST_WAIT_DONE) ? wait_inc : '0;
        frame_count_d = frame_count_q;
        start_d       = '0;
        cam_reset_d   = '0;
        sweep_done_d  = 1'b0;
        sweep_begin   = 1'b0;
        set_timeout   = 1'b0;
        set_overrun   = 1'b0;
        set_config    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (|cfg_enable_mask) begin
                        state_d     = ST_SELECT;
                        sweep_begin = 1'b1;
                    end else begin
                        set_config = 1'b1;
                    end
                end
            end
            ST_SELECT: begin
                if (stop || !sel_found) begin
                    state_d = ST_IDLE;
                end else if (!sel_blocked) begin
                    state_d = ST_START;
                    cam_d   = sel_idx;
                    start_d = sel_onehot;
                end
            end
            ST_START: begin
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (act_done || timed_out) begin
                    // A real done in the same cycle as the timeout still counts.
                    if (act_done) begin
                        frame_count_d = frame_count_q + FRAME_CNT_W'(1);
                    end else begin
                        set_timeout = 1'b1;
                        cam_reset_d = act_onehot;
                    end
                    ptr_d = PTR_W'(cam_q) + PTR_W'(1);
                    if (pend_stop_q || stop) begin
                        state_d = ST_IDLE;
                    end else if (|above_active) begin
                        state_d = ST_SELECT;
                    end else begin
                        state_d      = ST_GAP;
                        sweep_done_d = 1'b1;
                        gap_entry_d  = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (stop || !cfg_continuous) begin
                    state_d = ST_IDLE;
                end else if (period_inc >= cfg_period) begin
                    set_overrun = gap_entry_q;
                    if (|cfg_enable_mask) begin
                        state_d     = ST_SELECT;
                        sweep_begin = 1'b1;
                    end else begin
                        set_config = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (sweep_begin) begin
            mask_d       = cfg_enable_mask;
            ptr_d        = '0;
            period_cnt_d = '0;
        end
        if (state_d == ST_IDLE) begin
            pend_stop_d = 1'b0;
        end

        busy_d        = (state_d != ST_IDLE);
        err_timeout_d = set_timeout | (err_timeout_q & ~clear_errors);
        err_overrun_d = set_overrun | (err_overrun_q & ~clear_errors);
        err_config_d  = set_config  | (err_config_q  & ~clear_errors);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            mask_q        <= '0;
            ptr_q         <= '0;
            cam_q         <= '0;
            pend_stop_q   <= 1'b0;
            gap_entry_q   <= 1'b0;
            period_cnt_q  <= '0;
            wait_cnt_q    <= '0;
            frame_count_q <= '0;
            start_q       <= '0;
            cam_reset_q   <= '0;
            busy_q        <= 1'b0;
            sweep_done_q  <= 1'b0;
            err_timeout_q <= 1'b0;
            err_overrun_q <= 1'b0;
            err_config_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            mask_q        <= mask_d;
            ptr_q         <= ptr_d;
            cam_q         <= cam_d;
            pend_stop_q   <= pend_stop_d;
            gap_entry_q   <= gap_entry_d;
            period_cnt_q  <= period_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            frame_count_q <= frame_count_d;
            start_q       <= start_d;
            cam_reset_q   <= cam_reset_d;
            busy_q        <= busy_d;
            sweep_done_q  <= sweep_done_d;
            err_timeout_q <= err_timeout_d;
            err_overrun_q <= err_overrun_d;
            err_config_q  <= err_config_d;
        end
    end

    assign frame_capture_start = start_q;
    assign cam_reset           = cam_reset_q;
    assign active_cam          = cam_q;
    assign busy                = busy_q;
    assign sweep_done          = sweep_done_q;
    assign frame_count         = frame_count_q;
    assign err_timeout         = err_timeout_q;
    assign err_overrun         = err_overrun_q;
    assign err_config          = err_config_q;

endmodule

// File: tb/tb_imager_frame_scheduler.sv
// Scoreboard bench for imager_frame_scheduler: directed scenarios push the
// expected pulse events; a negedge monitor pops and compares them.
module tb_imager_frame_scheduler;

    localparam int NC = 4;
    localparam int PW = 24;

    logic            clk = 1'b0;
    logic            reset;
    logic [NC-1:0]   cfg_enable_mask;
    logic            cfg_continuous;
    logic [PW-1:0]   cfg_period;
    logic [PW-1:0]   cfg_timeout;
    logic            start;
    logic            stop;
    logic            clear_errors;
    logic [NC-1:0]   controller_busy;
    logic [NC-1:0]   frame_capture_done;
    logic [NC-1:0]   fifo_afull;
    logic [NC-1:0]   frame_capture_start;
    logic [NC-1:0]   cam_reset;
    logic [2:0]      active_cam;
    logic            busy;
    logic            sweep_done;
    logic [15:0]     frame_count;
    logic            err_timeout;
    logic            err_overrun;
    logic            err_config;

    imager_frame_scheduler #(.NUM_CAMS(NC), .PERIOD_W(PW)) dut (
        .clk                 (clk),
        .reset               (reset),
        .cfg_enable_mask     (cfg_enable_mask),
        .cfg_continuous      (cfg_continuous),
        .cfg_period          (cfg_period),
        .cfg_timeout         (cfg_timeout),
        .start               (start),
        .stop                (stop),
        .clear_errors        (clear_errors),
        .controller_busy     (controller_busy),
        .frame_capture_done  (frame_capture_done),
        .fifo_afull          (fifo_afull),
        .frame_capture_start (frame_capture_start),
        .cam_reset           (cam_reset),
        .active_cam          (active_cam),
        .busy                (busy),
        .sweep_done          (sweep_done),
        .frame_count         (frame_count),
        .err_timeout         (err_timeout),
        .err_overrun         (err_overrun),
        .err_config          (err_config)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 = frame_capture_start, 1 = cam_reset, 2 = sweep_done
    typedef struct {
        int kind;
        int cam;
        int at;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    task automatic expect_ev(input int kind, input int cam, input int at);
        ev_t e;
        e.kind = kind;
        e.cam  = cam;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind, input int cam);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event: got kind=%0d cam=%0d cyc=%0d, required no event", kind, cam, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cam != cam || e.at != cyc) begin
                n_bad++;
                $display("FAIL event: got kind=%0d cam=%0d cyc=%0d, required kind=%0d cam=%0d cyc=%0d",
                         kind, cam, cyc, e.kind, e.cam, e.at);
            end else begin
                $display("event kind=%0d cam=%0d cyc=%0d ok", kind, cam, cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            for (int c = 0; c < NC; c++) begin
                if (frame_capture_start[c]) observe(0, c);
            end
            for (int c = 0; c < NC; c++) begin
                if (cam_reset[c]) observe(1, c);
            end
            if (sweep_done) observe(2, 0);
        end
    end

    task automatic check(input string name, input int got, input int req);
        n_cmp++;
        if (got != req) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end else begin
            $display("check %s = %0d ok", name, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int k);
        while (cyc < k) step();
    endtask

    // Start is sampled on the next edge; s is that edge's cycle number.
    task automatic pulse_start(output int s);
        s = cyc + 1;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Drive done/stop/clear so they are sampled on edge k.
    task automatic pulse_at(input int k, input logic [NC-1:0] d, input logic s, input logic clr);
        wait_until(k - 1);
        frame_capture_done = d;
        stop               = s;
        clear_errors       = clr;
        step();
        frame_capture_done = '0;
        stop               = 1'b0;
        clear_errors       = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0; stop = 1'b0; clear_errors = 1'b0;
        frame_capture_done = '0; fifo_afull = '0; controller_busy = '0;
        step(); step(); step();
        check("rst_busy", int'(busy), 0);
        check("rst_pulses", int'({frame_capture_start, cam_reset, sweep_done}), 0);
        check("rst_frame_count", int'(frame_count), 0);
        check("rst_flags", int'({err_timeout, err_overrun, err_config}), 0);
        exp_q.delete();
        reset = 1'b0;
        step();
    endtask

    initial begin
        #2000000;
        $display("watchdog expired at cyc=%0d", cyc);
        $fatal(1, "bench did not finish in time");
    end

    initial begin
        int s;
        reset = 1'b1;
        cfg_enable_mask = '0; cfg_continuous = 1'b0; cfg_period = '0; cfg_timeout = '0;
        start = 1'b0; stop = 1'b0; clear_errors = 1'b0;
        controller_busy = '0; frame_capture_done = '0; fifo_afull = '0;
        do_reset();

        // Single sweep over cams 0,1; a stray done from cam1 is ignored.
        cfg_enable_mask = 4'b0011;
        pulse_start(s);
        expect_ev(0, 0, s + 1);
        expect_ev(0, 1, s + 12);
        expect_ev(2, 0, s + 22);
        pulse_at(s + 5, 4'b0010, 1'b0, 1'b0);
        pulse_at(s + 11, 4'b0001, 1'b0, 1'b0);
        pulse_at(s + 22, 4'b0010, 1'b0, 1'b0);
        wait_until(s + 24);
        check("single_frame_count", int'(frame_count), 2);
        check("single_busy_after", int'(busy), 0);
        check("single_drained", exp_q.size(), 0);

        // Timeout on cam0 after 50 wait cycles, then cam1 is served.
        do_reset();
        cfg_enable_mask = 4'b0011;
        cfg_timeout = 24'd50;
        pulse_start(s);
        expect_ev(0, 0, s + 1);
        expect_ev(1, 0, s + 52);
        expect_ev(0, 1, s + 53);
        expect_ev(2, 0, s + 60);
        wait_until(s + 51);
        check("timeout_flag_before", int'(err_timeout), 0);
        wait_until(s + 52);
        check("timeout_flag_set", int'(err_timeout), 1);
        check("timeout_frame_count", int'(frame_count), 0);
        pulse_at(s + 60, 4'b0010, 1'b0, 1'b0);
        wait_until(s + 62);
        check("timeout_frame_count_after", int'(frame_count), 1);
        check("timeout_drained", exp_q.size(), 0);

        // fifo_afull[0] stalls SELECT for 30 cycles; start follows the fall.
        do_reset();
        cfg_timeout = '0;
        cfg_enable_mask = 4'b0011;
        fifo_afull = 4'b0001;
        pulse_start(s);
        expect_ev(0, 0, s + 30);
        expect_ev(0, 1, s + 36);
        expect_ev(2, 0, s + 40);
        wait_until(s + 20);
        check("stall_busy", int'(busy), 1);
        wait_until(s + 29);
        fifo_afull = '0;
        pulse_at(s + 35, 4'b0001, 1'b0, 1'b0);
        pulse_at(s + 40, 4'b0010, 1'b0, 1'b0);
        wait_until(s + 42);
        check("stall_drained", exp_q.size(), 0);

        // stop in WAIT_DONE, done 5 cycles later: counted, no sweep_done.
        do_reset();
        cfg_enable_mask = 4'b0011;
        pulse_start(s);
        expect_ev(0, 0, s + 1);
        pulse_at(s + 4, 4'b0000, 1'b1, 1'b0);
        wait_until(s + 8);
        check("stop_busy_finishing", int'(busy), 1);
        pulse_at(s + 9, 4'b0001, 1'b0, 1'b0);
        wait_until(s + 30);
        check("stop_frame_count", int'(frame_count), 1);
        check("stop_busy_after", int'(busy), 0);
        check("stop_drained", exp_q.size(), 0);

        // stop and done in the same cycle: frame counted, back to IDLE.
        pulse_start(s);
        expect_ev(0, 0, s + 1);
        pulse_at(s + 6, 4'b0001, 1'b1, 1'b0);
        wait_until(s + 20);
        check("stopdone_frame_count", int'(frame_count), 2);
        check("stopdone_busy", int'(busy), 0);
        check("stopdone_drained", exp_q.size(), 0);

        // Empty mask: err_config, set beats clear, then clear works.
        cfg_enable_mask = 4'b0000;
        pulse_start(s);
        check("cfg_err_set", int'(err_config), 1);
        check("cfg_busy", int'(busy), 0);
        start = 1'b1;
        clear_errors = 1'b1;
        step();
        start = 1'b0;
        clear_errors = 1'b0;
        check("cfg_set_wins", int'(err_config), 1);
        pulse_at(cyc + 1, 4'b0000, 1'b0, 1'b1);
        check("cfg_cleared", int'(err_config), 0);

        // Continuous sweeps over cams 1,3 paced at 100 cycles.
        do_reset();
        cfg_enable_mask = 4'b1010;
        cfg_continuous = 1'b1;
        cfg_period = 24'd100;
        pulse_start(s);
        expect_ev(0, 1, s + 1);
        expect_ev(0, 3, s + 6);
        expect_ev(2, 0, s + 10);
        expect_ev(0, 1, s + 101);
        expect_ev(0, 3, s + 106);
        expect_ev(2, 0, s + 110);
        pulse_at(s + 5, 4'b0010, 1'b0, 1'b0);
        pulse_at(s + 10, 4'b1000, 1'b0, 1'b0);
        pulse_at(s + 105, 4'b0010, 1'b0, 1'b0);
        pulse_at(s + 110, 4'b1000, 1'b0, 1'b0);
        pulse_at(s + 150, 4'b0000, 1'b1, 1'b0);
        wait_until(s + 160);
        check("cont_overrun", int'(err_overrun), 0);
        check("cont_frame_count", int'(frame_count), 4);
        check("cont_busy_after_stop", int'(busy), 0);
        check("cont_drained", exp_q.size(), 0);

        // Period already elapsed on GAP entry: overrun, immediate re-sweep.
        do_reset();
        cfg_enable_mask = 4'b0001;
        cfg_continuous = 1'b1;
        cfg_period = 24'd5;
        pulse_start(s);
        expect_ev(0, 0, s + 1);
        expect_ev(2, 0, s + 10);
        expect_ev(0, 0, s + 12);
        pulse_at(s + 10, 4'b0001, 1'b0, 1'b0);
        wait_until(s + 11);
        check("overrun_flag", int'(err_overrun), 1);
        pulse_at(s + 14, 4'b0000, 1'b1, 1'b0);
        pulse_at(s + 16, 4'b0001, 1'b0, 1'b0);
        wait_until(s + 20);
        check("overrun_frame_count", int'(frame_count), 2);
        check("overrun_busy_after", int'(busy), 0);
        check("overrun_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
